// File: rtl/relu_maxpool2x2.sv
// -----------------------------------------------------------------------------
// relu_maxpool2x2
//   Streaming ReLU + requantisation + 2x2 max-pool (stride 2) over a square
//   IMG_W x IMG_W feature map delivered in raster order, one pixel per cycle
//   whenever i_data_valid_in is high. There is no backpressure.
//
//   Per accepted pixel: negative -> 0, otherwise i_data_in >>> SHIFT,
//   saturated to 2^(OUT_W-1)-1. Even columns load a pair holder. Odd columns
//   on even rows fold the pair max into a line buffer of IMG_W/2 entries.
//   Odd columns on odd rows emit max(holder, current, linebuf) one cycle
//   after the accepting edge.
//
// Ports
//   i_clk            clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   i_data_valid_in  i_data_in carries a pixel this cycle
//   i_data_in        signed conv pixel, IN_W bits
//   o_data_out       pooled pixel, unsigned OUT_W bits (holds while idle)
//   o_valid_out      one-cycle pulse per pooled pixel
//   o_frame_done     one-cycle pulse with the last pooled pixel of a frame
// -----------------------------------------------------------------------------
module relu_maxpool2x2 #(
   parameter int IMG_W = 28,
   parameter int IN_W  = 62,
   parameter int OUT_W = 32,
   parameter int SHIFT = 16
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_data_valid_in,
   input  logic signed [IN_W-1:0] i_data_in,
   output logic [OUT_W-1:0]       o_data_out,
   output logic                   o_valid_out,
   output logic                   o_frame_done
);

   localparam int CW   = (IMG_W > 2) ? $clog2(IMG_W) : 1;
   localparam int HALF = IMG_W / 2;
   localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;
   // Quantiser works at the wider of the two widths so the saturation compare
   // sees every magnitude bit that survives the shift.
   localparam int QW   = (IN_W > OUT_W) ? IN_W : OUT_W;

   localparam logic [CW-1:0] LAST_IDX = CW'(IMG_W - 1);
   localparam logic [QW-1:0] SAT_MAX  = {{(QW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};

   // ---------------------------------------------------------------- state
   logic [CW-1:0]    r_col;
   logic [CW-1:0]    r_row;
   logic [OUT_W-1:0] r_holder;
   logic [OUT_W-1:0] r_data_out;
   logic             r_valid_out;
   logic             r_frame_done;
   logic [OUT_W-1:0] r_linebuf [HALF];
   logic [OUT_W-1:0] r_lb_rd;

   // ---------------------------------------------------------------- comb
   logic [QW-1:0]    w_mag;
   logic [QW-1:0]    w_shifted;
   logic [OUT_W-1:0] w_q;
   logic [OUT_W-1:0] w_pair_max;
   logic [OUT_W-1:0] w_quad_max;
   logic [AW-1:0]    w_lb_addr;
   logic             w_col_odd;
   logic             w_row_odd;
   logic             w_col_last;
   logic             w_row_last;

   assign w_col_odd  = r_col[0];
   assign w_row_odd  = r_row[0];
   assign w_col_last = (r_col == LAST_IDX);
   assign w_row_last = (r_row == LAST_IDX);
   assign w_lb_addr  = AW'(r_col >> 1);

   // Sign bit selects ReLU; a non-negative value shifts identically under
   // logical and arithmetic shift, so the unsigned form is used.
   assign w_mag     = QW'($unsigned(i_data_in));
   assign w_shifted = w_mag >> SHIFT;

   always_comb begin
      w_q = '0;
      if (!i_data_in[IN_W-1]) begin
         if (w_shifted > SAT_MAX) begin
            w_q = SAT_MAX[OUT_W-1:0];
         end else begin
            w_q = w_shifted[OUT_W-1:0];
         end
      end
   end

   assign w_pair_max = (r_holder > w_q) ? r_holder : w_q;
   assign w_quad_max = (w_pair_max > r_lb_rd) ? w_pair_max : r_lb_rd;

   // ---------------------------------------------------------------- line buffer
   // Not reset: each entry is rewritten on an even row before the following
   // odd row reads it, so stale content can never reach the output.
   always_ff @(posedge i_clk) begin
      if (i_data_valid_in && w_col_odd && !w_row_odd) begin
         r_linebuf[w_lb_addr] <= w_pair_max;
      end
   end

   // Registered read is prefetched on the even column of an odd row, so the
   // entry is ready when the matching odd column arrives (gaps just hold it).
   always_ff @(posedge i_clk) begin
      if (i_data_valid_in && !w_col_odd && w_row_odd) begin
         r_lb_rd <= r_linebuf[w_lb_addr];
      end
   end

   // ---------------------------------------------------------------- control
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_col        <= '0;
         r_row        <= '0;
         r_holder     <= '0;
         r_data_out   <= '0;
         r_valid_out  <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_valid_out  <= 1'b0;
         r_frame_done <= 1'b0;
         if (i_data_valid_in) begin
            if (!w_col_odd) begin
               r_holder <= w_q;
            end else if (w_row_odd) begin
               r_data_out   <= w_quad_max;
               r_valid_out  <= 1'b1;
               r_frame_done <= w_row_last && w_col_last;
            end

            if (w_col_last) begin
               r_col <= '0;
               r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
         end
      end
   end

   assign o_data_out   = r_data_out;
   assign o_valid_out  = r_valid_out;
   assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_relu_maxpool2x2.sv
// -----------------------------------------------------------------------------
// tb_relu_maxpool2x2
//   Scoreboard bench. The stimulus side feeds pixels and a reference model
//   keeps the whole feature map as a 2-D array; whenever a pixel completes a
//   2x2 window the expected pooled value, frame_done flag and output cycle are
//   queued. A monitor on the falling edge pops and compares each DUT output.
// -----------------------------------------------------------------------------
module tb_relu_maxpool2x2;

   localparam int IMG_W = 28;
   localparam int IN_W  = 62;
   localparam int OUT_W = 32;
   localparam int SHIFT = 16;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   valid_in = 1'b0;
   logic signed [IN_W-1:0] data_in = '0;
   logic [OUT_W-1:0]       data_out;
   logic                   valid_out;
   logic                   frame_done;

   relu_maxpool2x2 #(
      .IMG_W(IMG_W), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)
   ) dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_data_valid_in (valid_in),
      .i_data_in       (data_in),
      .o_data_out      (data_out),
      .o_valid_out     (valid_out),
      .o_frame_done    (frame_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [OUT_W-1:0] data;
      logic             fd;
      int               cyc;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   n_out  = 0;

   // ---------------------------------------------------------------- model
   logic [OUT_W-1:0] img [IMG_W][IMG_W];
   int pr = 0;
   int pc = 0;

   function automatic logic [OUT_W-1:0] quant(input logic signed [IN_W-1:0] d);
      longint v;
      if (d < 0) return '0;
      v = longint'(d) / 65536;
      if (v > longint'(32'h7FFF_FFFF)) return 32'h7FFF_FFFF;
      return v[OUT_W-1:0];
   endfunction

   function automatic logic [OUT_W-1:0] max2(input logic [OUT_W-1:0] a, input logic [OUT_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

   task automatic model_accept(input logic signed [IN_W-1:0] d);
      exp_t e;
      img[pr][pc] = quant(d);
      if ((pr % 2 == 1) && (pc % 2 == 1)) begin
         e.data = max2(max2(img[pr-1][pc-1], img[pr-1][pc]),
                       max2(img[pr][pc-1],   img[pr][pc]));
         e.fd   = (pr == IMG_W-1) && (pc == IMG_W-1);
         e.cyc  = cyc + 1;
         sb.push_back(e);
      end
      pc++;
      if (pc == IMG_W) begin
         pc = 0;
         pr++;
         if (pr == IMG_W) pr = 0;
      end
   endtask

   // ---------------------------------------------------------------- stimulus
   function automatic logic signed [IN_W-1:0] rnd_pix();
      logic [63:0]            t;
      logic signed [IN_W-1:0] v;
      t = {$urandom, $urandom};
      t = t >> $urandom_range(2, 60);
      v = t[IN_W-1:0];
      if ($urandom_range(0, 3) == 0) v = -v;
      return v;
   endfunction

   // Called just after a rising edge; the pixel is taken on the next edge.
   task automatic send(input logic signed [IN_W-1:0] d, input int gap);
      valid_in = 1'b1;
      data_in  = d;
      model_accept(d);
      @(posedge clk); #1;
      valid_in = 1'b0;
      repeat (gap) begin
         data_in = rnd_pix();   // junk on idle cycles must be ignored
         @(posedge clk); #1;
      end
   endtask

   task automatic ramp_pixels(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         send(IN_W'(longint'(i)) <<< SHIFT, gap);
      end
   endtask

   task automatic const_frame(input logic signed [IN_W-1:0] d);
      for (int i = 0; i < IMG_W*IMG_W; i++) send(d, 0);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 20 && sb.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s: outputs outstanding=%0d, required 0", name, sb.size());
         sb.delete();
      end
   endtask

   // ---------------------------------------------------------------- monitor
   exp_t             e_mon;
   logic [OUT_W-1:0] last_data = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         checks++;
         if (data_out !== '0 || valid_out !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: data=%h valid=%b fd=%b, required 0/0/0",
                     data_out, valid_out, frame_done);
         end
      end else if (valid_out === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: data=%h fd=%b at cycle %0d, required none",
                     data_out, frame_done, cyc);
         end else begin
            e_mon = sb.pop_front();
            n_out++;
            if (data_out !== e_mon.data || frame_done !== e_mon.fd || cyc != e_mon.cyc) begin
               errors++;
               $display("FAIL pooled_pixel #%0d: data=%h fd=%b cycle=%0d, required data=%h fd=%b cycle=%0d",
                        n_out, data_out, frame_done, cyc, e_mon.data, e_mon.fd, e_mon.cyc);
            end else begin
               $display("out #%0d data=%h fd=%b cycle=%0d", n_out, data_out, frame_done, cyc);
            end
         end
      end else begin
         checks++;
         if (frame_done !== 1'b0 || data_out !== last_data) begin
            errors++;
            $display("FAIL idle_hold: data=%h fd=%b, required data=%h fd=0",
                     data_out, frame_done, last_data);
         end
      end
      last_data = data_out;
   end

   // ---------------------------------------------------------------- sequence
   initial begin
      // Reset held while pixels are offered: outputs must stay quiet.
      repeat (10) begin
         @(posedge clk); #1;
         valid_in = 1'b1;
         data_in  = rnd_pix();
      end
      valid_in = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Back-to-back frames: ramp, all negative, all saturating.
      ramp_pixels(IMG_W*IMG_W, 0);
      const_frame(-62'sd5);
      const_frame(62'sd1 <<< 60);
      // Ramp with alternating idle cycles.
      ramp_pixels(IMG_W*IMG_W, 1);
      // Random data with random gaps.
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < IMG_W*IMG_W; i++) send(rnd_pix(), $urandom_range(0, 1));
      end
      drain("random_frames");

      // Partial frame, then a reset discards it.
      ramp_pixels(300, 0);
      drain("partial_frame");
      rst_n = 1'b0;
      repeat (3) begin
         valid_in = 1'b1;
         data_in  = rnd_pix();
         @(posedge clk); #1;
      end
      valid_in = 1'b0;
      pr = 0;
      pc = 0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      ramp_pixels(IMG_W*IMG_W, 0);
      drain("post_reset_frame");

      repeat (5) begin
         @(posedge clk); #1;
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, outstanding=%0d", sb.size());
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/relu_maxpool2x2.md
RELU_MAXPOOL2X2 -- requirements
Module: relu_maxpool2x2

Interface
REQ-001 Parameter IMG_W, default 28: conv2d output feature-map width and height in pixels; SHALL be even.
REQ-002 Parameter IN_W, default 62: input pixel width; signed two's complement, matching conv2d data_out.
REQ-003 Parameter OUT_W, default 32: output pixel width, unsigned.
REQ-004 Parameter SHIFT, default 16: arithmetic right-shift applied for requantisation.
REQ-005 CLK  input  1  single clock; all state updates on rising edge.
REQ-006 RST  input  1  asynchronous, active-low reset.
REQ-007 data_valid_in  input  1  data_in holds a valid conv pixel this cycle; driven from conv2d valid_out.
REQ-008 data_in  input  IN_W  signed conv pixel, raster order (row-major), from conv2d data_out.
REQ-009 data_out  output  OUT_W  pooled, requantised pixel.
REQ-010 valid_out  output  1  data_out valid this cycle; single-cycle pulse per pooled pixel.
REQ-011 frame_done  output  1  one-cycle pulse coincident with the last pooled pixel of a frame.

Function
REQ-012 The block SHALL apply no backpressure; every cycle with data_valid_in=1 consumes exactly one pixel.
REQ-013 Quantise per accepted pixel: negative -> 0 (ReLU); otherwise data_in >>> SHIFT; if the result exceeds 2^(OUT_W-1)-1, saturate to 2^(OUT_W-1)-1 (0x7FFF_FFFF at defaults).
REQ-014 Column counter col (0..IMG_W-1) and row counter row (0..IMG_W-1) SHALL advance only on accepted pixels; col wraps to 0 and increments row at IMG_W-1; row wraps to 0 after the last pixel of a frame.
REQ-015 Even col: register the quantised pixel as the pair holder.
REQ-016 Odd col, even row: store max(holder, current) into line buffer entry col/2 (IMG_W/2 entries x OUT_W).
REQ-017 Odd col, odd row: output max(holder, current, linebuf[col/2]) on data_out with valid_out=1 on the next rising edge (latency 1 cycle from the accepting edge).
REQ-018 Comparisons SHALL be unsigned on OUT_W-bit quantised values; ties yield that same value.
REQ-019 Output count per frame SHALL be (IMG_W/2)^2 (196 at defaults), in raster order of the pooled map.
REQ-020 frame_done SHALL assert together with valid_out for the pixel produced at row=col=IMG_W-1.
REQ-021 Idle cycles (data_valid_in=0) at any position SHALL leave counters, holder and line buffer unchanged and SHALL NOT alter output values versus a gap-free stream.
REQ-022 valid_out and frame_done SHALL be 0 in every cycle not specified by REQ-017/REQ-020; data_out holds its last value while valid_out=0.
REQ-023 Line buffer content SHALL be unaffected by reset; every entry is rewritten on an even row before it is read on the following odd row.
REQ-024 Back-to-back frames SHALL be processed with no idle cycle required between the last pixel of one frame and the first pixel of the next.

Reset
REQ-025 RST=0 SHALL immediately force data_out=0, valid_out=0, frame_done=0, col=0, row=0, holder=0.
REQ-026 Reset mid-frame SHALL discard the partial frame; the first accepted pixel after RST rises is row 0, col 0.
REQ-027 Pixels presented while RST=0 SHALL be ignored.

Verification
REQ-028 Reset: hold RST=0 with data_valid_in=1 and random data -> data_out=0, valid_out=0, frame_done=0 throughout.
REQ-029 Ramp: pixel (r,c) = (r*28+c)<<16, continuous valid -> 196 outputs; first = 29, second = 31, last = 783 with frame_done=1; each output one cycle after its (odd,odd) input.
REQ-030 ReLU: full frame of data_in = -5 -> 196 outputs, all 0.
REQ-031 Saturation: full frame of data_in = 2^60 -> 196 outputs, all 0x7FFF_FFFF.
REQ-032 Gaps: ramp frame with data_valid_in alternating 1/0 -> same 196 values and order as REQ-029; frame_done exactly once.
REQ-033 Mid-frame reset: pulse RST low after pixel 300, then a full ramp frame -> exactly 196 outputs matching REQ-029, one frame_done.
